// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// Reusable elastic pipeline register for the inter-stage boundaries
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data field and a control
// field, with a valid/ready handshake on each side.
//
// Parameters:
//   DATA_W     payload width (instr, npc, aluout, ...)
//   CTRL_W     control width (rfWEN, dREN, dWEN, halt, ...)
//   SKID       0: one entry, combinational in_ready
//              1: main + skid entry, registered in_ready
//   CLEAR_DATA 1: flush zeroes data, 0: flush leaves data stale
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   flush                 squash every held entry
//   in_valid / in_ready   upstream handshake, in_data / in_ctrl payload
//   out_valid / out_ready downstream handshake, out_data / out_ctrl head entry
//   occupancy             entries held (0..2)
//   stall_cnt             saturating count of back-pressured cycles
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid = 0
// ST_ONE   | head entry in main
// ST_TWO   | head in main, next entry in skid (SKID = 1 only)

module pipe_stage_elastic #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 8,
    parameter int SKID       = 0,
    parameter int CLEAR_DATA = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [15:0]         r_stall_cnt;

    logic   w_out_valid;
    logic   w_in_ready;
    logic   w_in_fire;
    logic   w_out_fire;
    state_t w_state_nxt;

    assign w_out_valid = (r_state != ST_EMPTY);
    // Without a skid entry, ready must look straight through to downstream
    // to keep full throughput; with one, it is taken from a flop.
    assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || out_ready);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_fire) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire)
                        w_state_nxt = (SKID != 0) ? ST_TWO : ST_ONE;
                    else if (!w_in_fire && w_out_fire)
                        w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_out_fire) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;

            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);

            if (flush) begin
                // An in_fire this cycle is dropped: upstream squashes it too.
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
                if (CLEAR_DATA != 0) begin
                    r_main_data <= '0;
                    r_skid_data <= '0;
                end
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            r_main_data <= in_data;
                            r_main_ctrl <= in_ctrl;
                        end
                    end
                    ST_ONE: begin
                        if (w_in_fire && w_out_fire) begin
                            r_main_data <= in_data;
                            r_main_ctrl <= in_ctrl;
                        end else if (w_in_fire && (SKID != 0)) begin
                            r_skid_data <= in_data;
                            r_skid_ctrl <= in_ctrl;
                        end
                    end
                    ST_TWO: begin
                        if (w_out_fire) begin
                            r_main_data <= r_skid_data;
                            r_main_ctrl <= r_skid_ctrl;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    // A bubble must never carry write enables downstream.
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic. Two instances share the clock and
// reset: u0 is SKID=0/CLEAR_DATA=1, u1 is SKID=1/CLEAR_DATA=0.

module tb_pipe_stage_elastic;

    logic CLK = 1'b0;
    logic RST;

    logic        flush_0, in_valid_0, in_ready_0, out_valid_0, out_ready_0;
    logic [15:0] in_data_0, out_data_0, stall_cnt_0;
    logic [7:0]  in_ctrl_0, out_ctrl_0;
    logic [1:0]  occupancy_0;

    logic        flush_1, in_valid_1, in_ready_1, out_valid_1, out_ready_1;
    logic [15:0] in_data_1, out_data_1, stall_cnt_1;
    logic [7:0]  in_ctrl_1, out_ctrl_1;
    logic [1:0]  occupancy_1;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.DATA_W(16), .CTRL_W(8), .SKID(0), .CLEAR_DATA(1)) u0 (
        .CLK(CLK), .RST(RST), .flush(flush_0),
        .in_valid(in_valid_0), .in_ready(in_ready_0),
        .in_data(in_data_0), .in_ctrl(in_ctrl_0),
        .out_valid(out_valid_0), .out_ready(out_ready_0),
        .out_data(out_data_0), .out_ctrl(out_ctrl_0),
        .occupancy(occupancy_0), .stall_cnt(stall_cnt_0)
    );

    pipe_stage_elastic #(.DATA_W(16), .CTRL_W(8), .SKID(1), .CLEAR_DATA(0)) u1 (
        .CLK(CLK), .RST(RST), .flush(flush_1),
        .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_data(in_data_1), .in_ctrl(in_ctrl_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_data(out_data_1), .out_ctrl(out_ctrl_1),
        .occupancy(occupancy_1), .stall_cnt(stall_cnt_1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        #1;
        n_vec++; if (out_valid_0 !== 1'b0) begin n_err++; $display("FAIL rst_valid0 got %b exp 0", out_valid_0); end
        n_vec++; if (out_data_0 !== 16'h0) begin n_err++; $display("FAIL rst_data0 got %h exp 0000", out_data_0); end
        n_vec++; if (occupancy_0 !== 2'd0) begin n_err++; $display("FAIL rst_occ0 got %0d exp 0", occupancy_0); end
        n_vec++; if (in_ready_0 !== 1'b1) begin n_err++; $display("FAIL rst_rdy0 got %b exp 1", in_ready_0); end
        n_vec++; if (out_valid_1 !== 1'b0) begin n_err++; $display("FAIL rst_valid1 got %b exp 0", out_valid_1); end
        n_vec++; if (out_ctrl_1 !== 8'h0) begin n_err++; $display("FAIL rst_ctrl1 got %h exp 00", out_ctrl_1); end
        n_vec++; if (stall_cnt_1 !== 16'h0) begin n_err++; $display("FAIL rst_stall1 got %h exp 0000", stall_cnt_1); end
        n_vec++; if (in_ready_1 !== 1'b1) begin n_err++; $display("FAIL rst_rdy1 got %b exp 1", in_ready_1); end
    endtask

    // Both instances stream 1,2,3 with out_ready=1: no gaps, 1-cycle latency.
    task automatic test_pass_through();
        logic [15:0] exp_d;
        out_ready_0 = 1'b1; out_ready_1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_d = 16'(i);
            in_valid_0 = 1'b1; in_data_0 = exp_d; in_ctrl_0 = 8'(i * 16'h11);
            in_valid_1 = 1'b1; in_data_1 = exp_d; in_ctrl_1 = 8'(i * 16'h11);
            tick();
            n_vec++; if (out_valid_0 !== 1'b1 || out_data_0 !== exp_d) begin n_err++; $display("FAIL pt0_data%0d got v=%b d=%h exp v=1 d=%h", i, out_valid_0, out_data_0, exp_d); end
            n_vec++; if (out_ctrl_0 !== 8'(i * 16'h11)) begin n_err++; $display("FAIL pt0_ctrl%0d got %h exp %h", i, out_ctrl_0, 8'(i * 16'h11)); end
            n_vec++; if (out_valid_1 !== 1'b1 || out_data_1 !== exp_d || in_ready_1 !== 1'b1) begin n_err++; $display("FAIL pt1_data%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=1", i, out_valid_1, out_data_1, in_ready_1, exp_d); end
        end
        in_valid_0 = 1'b0; in_valid_1 = 1'b0;
        tick();
        n_vec++; if (out_valid_0 !== 1'b0 || occupancy_0 !== 2'd0) begin n_err++; $display("FAIL pt0_drain got v=%b occ=%0d exp v=0 occ=0", out_valid_0, occupancy_0); end
        n_vec++; if (out_ctrl_0 !== 8'h0) begin n_err++; $display("FAIL pt0_bubble_ctrl got %h exp 00", out_ctrl_0); end
        n_vec++; if (occupancy_1 !== 2'd0) begin n_err++; $display("FAIL pt1_drain got occ=%0d exp 0", occupancy_1); end
        n_vec++; if (stall_cnt_0 !== 16'h0 || stall_cnt_1 !== 16'h0) begin n_err++; $display("FAIL pt_stall got %h/%h exp 0000/0000", stall_cnt_0, stall_cnt_1); end
    endtask

    // u1: A accepted, then out_ready=0; B goes to skid, C waits upstream.
    task automatic test_skid_absorb();
        in_valid_1 = 1'b1; in_data_1 = 16'h00AA; in_ctrl_1 = 8'h0A; out_ready_1 = 1'b1;
        tick();
        n_vec++; if (occupancy_1 !== 2'd1 || in_ready_1 !== 1'b1) begin n_err++; $display("FAIL sk_a got occ=%0d rdy=%b exp occ=1 rdy=1", occupancy_1, in_ready_1); end
        out_ready_1 = 1'b0; in_data_1 = 16'h00BB; in_ctrl_1 = 8'h0B;
        tick();
        n_vec++; if (occupancy_1 !== 2'd2 || in_ready_1 !== 1'b0) begin n_err++; $display("FAIL sk_b got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy_1, in_ready_1); end
        n_vec++; if (out_data_1 !== 16'h00AA) begin n_err++; $display("FAIL sk_head got %h exp 00aa", out_data_1); end
        in_data_1 = 16'h00CC; in_ctrl_1 = 8'h0C;
        tick();
        n_vec++; if (occupancy_1 !== 2'd2 || in_ready_1 !== 1'b0 || out_data_1 !== 16'h00AA) begin n_err++; $display("FAIL sk_hold got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=00aa", occupancy_1, in_ready_1, out_data_1); end
        tick();
        out_ready_1 = 1'b1;
        tick();
        n_vec++; if (out_data_1 !== 16'h00BB || occupancy_1 !== 2'd1 || in_ready_1 !== 1'b1) begin n_err++; $display("FAIL sk_rel_b got d=%h occ=%0d rdy=%b exp d=00bb occ=1 rdy=1", out_data_1, occupancy_1, in_ready_1); end
        n_vec++; if (out_ctrl_1 !== 8'h0B) begin n_err++; $display("FAIL sk_rel_bctrl got %h exp 0b", out_ctrl_1); end
        tick();
        n_vec++; if (out_data_1 !== 16'h00CC || out_valid_1 !== 1'b1) begin n_err++; $display("FAIL sk_rel_c got d=%h v=%b exp d=00cc v=1", out_data_1, out_valid_1); end
        in_valid_1 = 1'b0;
        tick();
        n_vec++; if (out_valid_1 !== 1'b0 || occupancy_1 !== 2'd0) begin n_err++; $display("FAIL sk_drain got v=%b occ=%0d exp v=0 occ=0", out_valid_1, occupancy_1); end
        n_vec++; if (stall_cnt_1 !== 16'd3) begin n_err++; $display("FAIL sk_stall got %0d exp 3", stall_cnt_1); end
    endtask

    // u0 holds one FF-ctrl entry; u1 holds two (TWO) under stall; flush both.
    task automatic test_flush_bubble();
        out_ready_0 = 1'b0; out_ready_1 = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'h1234; in_ctrl_0 = 8'hFF;
        in_valid_1 = 1'b1; in_data_1 = 16'h5678; in_ctrl_1 = 8'hFF;
        tick();
        in_valid_0 = 1'b0;
        in_data_1 = 16'h9999;
        #1;
        n_vec++; if (in_ready_0 !== 1'b0) begin n_err++; $display("FAIL fl_stall_rdy0 got %b exp 0", in_ready_0); end
        n_vec++; if (out_ctrl_0 !== 8'hFF) begin n_err++; $display("FAIL fl_pre_ctrl0 got %h exp ff", out_ctrl_0); end
        out_ready_0 = 1'b1;
        #1;
        n_vec++; if (in_ready_0 !== 1'b1) begin n_err++; $display("FAIL fl_comb_rdy0 got %b exp 1", in_ready_0); end
        out_ready_0 = 1'b0;
        tick();
        in_valid_1 = 1'b0;
        n_vec++; if (occupancy_1 !== 2'd2 || in_ready_1 !== 1'b0) begin n_err++; $display("FAIL fl_pre_two got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy_1, in_ready_1); end
        flush_0 = 1'b1; flush_1 = 1'b1;
        tick();
        flush_0 = 1'b0; flush_1 = 1'b0;
        n_vec++; if (out_valid_0 !== 1'b0 || out_ctrl_0 !== 8'h0 || occupancy_0 !== 2'd0) begin n_err++; $display("FAIL fl_bub0 got v=%b c=%h occ=%0d exp v=0 c=00 occ=0", out_valid_0, out_ctrl_0, occupancy_0); end
        n_vec++; if (out_data_0 !== 16'h0) begin n_err++; $display("FAIL fl_data0 got %h exp 0000", out_data_0); end
        n_vec++; if (stall_cnt_0 !== 16'd2) begin n_err++; $display("FAIL fl_stall0 got %0d exp 2", stall_cnt_0); end
        n_vec++; if (out_valid_1 !== 1'b0 || out_ctrl_1 !== 8'h0 || occupancy_1 !== 2'd0) begin n_err++; $display("FAIL fl_bub1 got v=%b c=%h occ=%0d exp v=0 c=00 occ=0", out_valid_1, out_ctrl_1, occupancy_1); end
        n_vec++; if (out_data_1 !== 16'h5678) begin n_err++; $display("FAIL fl_data1 got %h exp 5678", out_data_1); end
        n_vec++; if (in_ready_1 !== 1'b1) begin n_err++; $display("FAIL fl_rdy1 got %b exp 1", in_ready_1); end
        n_vec++; if (stall_cnt_1 !== 16'd5) begin n_err++; $display("FAIL fl_stall1 got %0d exp 5", stall_cnt_1); end
        out_ready_0 = 1'b1; out_ready_1 = 1'b1;
    endtask

    task automatic test_flush_infire();
        in_valid_0 = 1'b1; in_data_0 = 16'hDDDD; in_ctrl_0 = 8'h5A; flush_0 = 1'b1;
        tick();
        in_valid_0 = 1'b0; flush_0 = 1'b0;
        n_vec++; if (out_valid_0 !== 1'b0 || out_data_0 === 16'hDDDD) begin n_err++; $display("FAIL fi_drop got v=%b d=%h exp v=0 d!=dddd", out_valid_0, out_data_0); end
        tick();
        n_vec++; if (out_valid_0 !== 1'b0 || occupancy_0 !== 2'd0) begin n_err++; $display("FAIL fi_later got v=%b occ=%0d exp v=0 occ=0", out_valid_0, occupancy_0); end
    endtask

    task automatic test_reset_mid();
        out_ready_1 = 1'b0;
        in_valid_1 = 1'b1; in_data_1 = 16'h0101; in_ctrl_1 = 8'h01;
        tick();
        in_data_1 = 16'h0202; in_ctrl_1 = 8'h02;
        tick();
        n_vec++; if (occupancy_1 !== 2'd2) begin n_err++; $display("FAIL rm_pre got occ=%0d exp 2", occupancy_1); end
        RST = 1'b1;
        tick();
        n_vec++; if (out_valid_1 !== 1'b0 || out_data_1 !== 16'h0 || out_ctrl_1 !== 8'h0 || occupancy_1 !== 2'd0 || stall_cnt_1 !== 16'h0) begin n_err++; $display("FAIL rm_vals got v=%b d=%h c=%h occ=%0d st=%h exp all 0", out_valid_1, out_data_1, out_ctrl_1, occupancy_1, stall_cnt_1); end
        n_vec++; if (stall_cnt_0 !== 16'h0) begin n_err++; $display("FAIL rm_stall0 got %h exp 0000", stall_cnt_0); end
        RST = 1'b0; out_ready_1 = 1'b1;
        in_data_1 = 16'h0077; in_ctrl_1 = 8'h07;
        #1;
        n_vec++; if (in_ready_1 !== 1'b1) begin n_err++; $display("FAIL rm_rdy got %b exp 1", in_ready_1); end
        tick();
        in_valid_1 = 1'b0;
        n_vec++; if (out_valid_1 !== 1'b1 || out_data_1 !== 16'h0077 || out_ctrl_1 !== 8'h07) begin n_err++; $display("FAIL rm_first got v=%b d=%h c=%h exp v=1 d=0077 c=07", out_valid_1, out_data_1, out_ctrl_1); end
        tick();
    endtask

    task automatic test_saturation();
        out_ready_0 = 1'b0;
        in_valid_0 = 1'b1; in_data_0 = 16'h4242; in_ctrl_0 = 8'h42;
        tick();
        in_valid_0 = 1'b0;
        repeat (65534) tick();
        n_vec++; if (stall_cnt_0 !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe got %h exp fffe", stall_cnt_0); end
        tick();
        n_vec++; if (stall_cnt_0 !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got %h exp ffff", stall_cnt_0); end
        repeat (4465) tick();
        n_vec++; if (stall_cnt_0 !== 16'hFFFF || out_valid_0 !== 1'b1) begin n_err++; $display("FAIL sat_hold got st=%h v=%b exp st=ffff v=1", stall_cnt_0, out_valid_0); end
        n_vec++; if (out_data_0 !== 16'h4242) begin n_err++; $display("FAIL sat_data got %h exp 4242", out_data_0); end
    endtask

    initial begin
        RST = 1'b1;
        flush_0 = 1'b0; in_valid_0 = 1'b0; in_data_0 = '0; in_ctrl_0 = '0; out_ready_0 = 1'b1;
        flush_1 = 1'b0; in_valid_1 = 1'b0; in_data_1 = '0; in_ctrl_1 = '0; out_ready_1 = 1'b1;
        test_reset();
        test_pass_through();
        test_skid_absorb();
        test_flush_bubble();
        test_flush_infire();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
